// File: rtl/data_mem_responder_pkg.sv
// memory_map: address constants, region encoding and decoder for the data-memory port
package memory_map;
  localparam logic [31:0] RAM_BASE = 32'h0000_0000;
  localparam logic [31:0] MSIP_ADDR = 32'h0200_0000;
  localparam logic [31:0] MTIMECMP_ADDR = 32'h0200_4000;
  localparam logic [31:0] MTIME_ADDR = 32'h0200_BFF8;
  typedef enum logic [2:0] {RAM, MSIP, MTIMECMP_LO, MTIMECMP_HI, MTIME_LO, MTIME_HI, UNMAPPED} region_t;
  function automatic region_t decode(input logic [31:0] addr, input int unsigned words);
    logic [31:0] a, off;
    a = addr & ~32'h3;
    off = a - RAM_BASE;
    return (a >= RAM_BASE && off < (words << 2)) ? RAM :
           a == MSIP_ADDR ? MSIP :
           a == MTIMECMP_ADDR ? MTIMECMP_LO :
           a == MTIMECMP_ADDR + 32'd4 ? MTIMECMP_HI :
           a == MTIME_ADDR ? MTIME_LO :
           a == MTIME_ADDR + 32'd4 ? MTIME_HI : UNMAPPED;
  endfunction
endpackage

// File: rtl/data_mem_responder_clint_timer.sv
// clint_timer: msip/mtime/mtimecmp registers with prescaled mtime and registered interrupts
module clint_timer import memory_map::*; #(
  parameter int unsigned TIME_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  region_t     sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        timer_int_o,
  output logic        soft_int_o
);
  logic        msip_q, msip_d, timer_q, soft_q, tick;
  logic [31:0] pre_q, pre_d;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  always_comb begin
    tick = pre_q == 32'(TIME_DIV - 1);
    pre_d = tick ? '0 : pre_q + 32'd1;
    msip_d = (we_i && sel_i == MSIP) ? wdata_i[0] : msip_q;
    mtimecmp_d = (we_i && sel_i == MTIMECMP_LO) ? {mtimecmp_q[63:32], wdata_i} :
                 (we_i && sel_i == MTIMECMP_HI) ? {wdata_i, mtimecmp_q[31:0]} : mtimecmp_q;
    // a software write to either half wins over this cycle's increment
    mtime_d = (we_i && sel_i == MTIME_LO) ? {mtime_q[63:32], wdata_i} :
              (we_i && sel_i == MTIME_HI) ? {wdata_i, mtime_q[31:0]} : mtime_q + 64'(tick);
    rdata_o = sel_i == MSIP ? {31'b0, msip_q} :
              sel_i == MTIMECMP_LO ? mtimecmp_q[31:0] :
              sel_i == MTIMECMP_HI ? mtimecmp_q[63:32] :
              sel_i == MTIME_LO ? mtime_q[31:0] :
              sel_i == MTIME_HI ? mtime_q[63:32] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q <= 1'b0;
      pre_q <= '0;
      mtime_q <= '0;
      mtimecmp_q <= '1;
      timer_q <= 1'b0;
      soft_q <= 1'b0;
    end else begin
      msip_q <= msip_d;
      pre_q <= pre_d;
      mtime_q <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      timer_q <= mtime_q >= mtimecmp_q;
      soft_q <= msip_q;
    end
  end
  assign timer_int_o = timer_q;
  assign soft_int_o = soft_q;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency data-memory slave with byte-strobed RAM and CLINT timer
module data_mem_responder import memory_map::*; #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WRITE_LATENCY = 1,
  parameter int unsigned TIME_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read_enable,
  output logic        read_valid,
  output logic [31:0] read_data,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic [3:0]  strb,
  output logic        write_ready,
  output logic        access_fault,
  output logic        timer_int,
  output logic        soft_int
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, BUSY_R, BUSY_W, DONE} state_t;
  state_t      state_q, state_d;
  region_t     region;
  logic [3:0]  cnt_q, cnt_d, strb_q;
  logic [31:0] addr_q, addr_d, wdata_q, rdata_q, ram_word, clint_rdata;
  logic [AW-1:0] idx;
  logic        rv_q, wr_q, af_q, acc_w, acc_r, resp_r, resp_w, commit;
  logic [31:0] mem [MEM_WORDS];
  always_comb begin
    addr_d = state_q == IDLE ? address : addr_q;
    region = decode(addr_d, MEM_WORDS);
    idx = addr_d[AW+1:2];
    ram_word = mem[idx];
    acc_w = state_q == IDLE && write_enable;
    acc_r = state_q == IDLE && !write_enable && read_enable;
    // outputs are registered, so flag the edge that enters the response cycle
    resp_r = (acc_r && READ_LATENCY == 1) || (state_q == BUSY_R && cnt_q == 4'd1);
    resp_w = (acc_w && WRITE_LATENCY == 1) || (state_q == BUSY_W && cnt_q == 4'd1);
    commit = state_q == BUSY_W && cnt_q == 4'd0;
    cnt_d = acc_w ? 4'(WRITE_LATENCY - 1) : acc_r ? 4'(READ_LATENCY - 1) : cnt_q - 4'd1;
    state_d = acc_w ? BUSY_W : acc_r ? BUSY_R : state_q == DONE ? IDLE :
              (state_q != IDLE && cnt_q == 4'd0) ? DONE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      rv_q <= 1'b0;
      wr_q <= 1'b0;
      af_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      if (acc_w) begin
        wdata_q <= write_data;
        strb_q <= strb;
      end
      rv_q <= resp_r;
      wr_q <= resp_w;
      af_q <= (resp_r || resp_w) && region == UNMAPPED;
      if (resp_r) rdata_q <= region == RAM ? ram_word : clint_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && commit && region == RAM)
      for (int i = 0; i < 4; i++)
        if (strb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
  end
  clint_timer #(.TIME_DIV(TIME_DIV)) u_clint (
    .clk        (clk),
    .rst        (rst),
    .we_i       (commit),
    .sel_i      (region),
    .wdata_i    (wdata_q),
    .rdata_o    (clint_rdata),
    .timer_int_o(timer_int),
    .soft_int_o (soft_int)
  );
  assign read_valid = rv_q;
  assign write_ready = wr_q;
  assign access_fault = af_q;
  assign read_data = rdata_q;
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Target-side responder for the core's data-memory interface: receives read_enable/write_enable requests and answers with read_valid/write_ready after a fixed, configurable latency.
- Contains a word-addressed RAM with byte-strobe writes.
- Contains a CLINT-style timer block (msip, mtime, mtimecmp) that drives the core's soft_int and timer_int inputs.
- Sits between the core's load/store port and the system memory map; it is the only slave on that port.

Parameters:
- MEM_WORDS, 4096, RAM depth in 32-bit words; RAM is based at 0x0000_0000.
- READ_LATENCY, 2, cycles from request acceptance to read_valid; legal range 1..15.
- WRITE_LATENCY, 1, cycles from request acceptance to write_ready; legal range 1..15.
- TIME_DIV, 1, clk cycles per mtime increment; minimum 1.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- address, in, 32, byte address from core.
- read_enable, in, 1, read request; level, held until read_valid.
- read_valid, out, 1, one-cycle pulse; read_data is valid in this cycle.
- read_data, out, 32, read result.
- write_data, in, 32, store data (lane-aligned).
- write_enable, in, 1, write request; level, held until write_ready.
- strb, in, 4, byte-lane enables for writes.
- write_ready, out, 1, one-cycle pulse; write completed.
- access_fault, out, 1, one-cycle pulse alongside read_valid/write_ready when the address is unmapped.
- timer_int, out, 1, mtime >= mtimecmp (unsigned 64-bit).
- soft_int, out, 1, msip[0].

Behaviour:
- Reset values: read_valid, write_ready, access_fault = 0; read_data = 0; mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; msip = 0; FSM = IDLE.
- RAM contents are not reset.
- Reset mid-transaction aborts the transaction with no response, and a pending write is dropped.
- FSM state IDLE:
  - If write_enable = 1: capture address, write_data and strb; load counter with WRITE_LATENCY-1; go to BUSY_W.
  - Else if read_enable = 1: capture address; load counter with READ_LATENCY-1; go to BUSY_R.
  - Write has priority. A simultaneous read stays pending, because the core holds it, and is accepted after the write finishes.
- FSM state BUSY_R / BUSY_W:
  - Decrement the counter each cycle.
  - When the counter is 0, the current cycle is the response cycle: assert read_valid or write_ready for exactly this cycle, then go to DONE.
  - With latency 1, the response occurs in the cycle immediately after acceptance. In general, acceptance edge at T gives the response at T+LATENCY.
- FSM state DONE: one turnaround cycle in which enables are ignored, so the core can drop its request registered; then go to IDLE.
- Throughput: at most one transaction per LATENCY+2 cycles.
- Address decode uses the captured address; bits [1:0] are ignored (word-aligned).
  - 0x0000_0000 .. 4*MEM_WORDS-1: RAM.
  - 0x0200_0000: msip.
  - 0x0200_4000 / 0x0200_4004: mtimecmp low / high.
  - 0x0200_BFF8 / 0x0200_BFFC: mtime low / high.
  - Anything else: unmapped.
- RAM reads: read_data is the full word.
- RAM writes: each lane i with strb[i] = 1 is updated with write_data[8i+7:8i]; the update happens at the end of the write_ready cycle. strb = 0 completes with no change.
- CLINT registers: strb is ignored and the full word is written.
  - msip: only bit 0 is writable; the other bits read 0.
- Unmapped addresses:
  - Read returns 0 and pulses access_fault.
  - Write is dropped and pulses access_fault.
- mtime:
  - Increments by 1 every TIME_DIV cycles via a prescaler counter; wraps at 2^64.
  - A software write to a half of mtime takes precedence over the increment in that cycle; the prescaler is not reset by the write.
- timer_int and soft_int are registered: they update the cycle after the mtime, mtimecmp or msip change.

Decomposition:
- Shared package memory_map holds:
  - RAM_BASE and the CLINT address constants: MSIP_ADDR, MTIMECMP_ADDR, MTIME_ADDR.
  - The region enum region_t: RAM, MSIP, MTIMECMP_LO, MTIMECMP_HI, MTIME_LO, MTIME_HI, UNMAPPED.
- The FSM state enum stays local to the module.
- Sub-module clint_timer holds msip, mtime, mtimecmp, the prescaler and the interrupt outputs, with a simple register write/read port.
- The RAM and FSM stay in the top module.

Test Plan:
- Write then read the same word. Stimulus: write 0xDEADBEEF, strb=4'hF to 0x100; then read 0x100 (READ_LATENCY=2, WRITE_LATENCY=1). Response: write_ready 1 cycle after acceptance; read_valid 2 cycles after acceptance with read_data=0xDEADBEEF; no access_fault.
- Byte strobes. Stimulus: over 0x11223344 at 0x104, write 0xAABBCCDD with strb=4'b0101; then read 0x104. Response: read_data = 0x11BB33DD.
- Simultaneous enables and handshake timing. Stimulus: write_enable and read_enable both high in IDLE. Response: the write completes first, DONE lasts 1 cycle, then the read is accepted; each response pulse is exactly 1 cycle wide.
- Unmapped access. Stimulus: read 0x1000_0000. Response: read_data=0 and access_fault=1 in the read_valid cycle. A write to the same address also pulses access_fault and leaves RAM unchanged.
- Timer interrupt. Stimulus: TIME_DIV=1; write mtimecmp_hi=0 then mtimecmp_lo=20. Response: timer_int rises the cycle after mtime reaches 20. Writing mtimecmp_lo=0xFFFFFFFF and mtimecmp_hi=0xFFFFFFFF clears timer_int.
- Soft interrupt and reset. Stimulus: write msip=0xFFFFFFFF. Response: soft_int=1; a read of msip returns 0x1. Then assert rst during a pending BUSY_R: no read_valid is issued, soft_int=0, mtime=0.
